// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares the single write port of the register file between two requesters
// (A: ALU writeback, B: load/immediate path). Arbitration is round-robin over a
// valid/grant handshake. A clear sweep writes zero to every register through
// the same write port, one address per cycle.
//
// Ports
//   CLK                 clock, all state updates on the rising edge
//   RESET               synchronous, active-low reset
//   A_REQ/A_ADDR/A_DATA port A request, destination register, write data
//   A_GNT               port A grant (combinational)
//   B_REQ/B_ADDR/B_DATA port B request, destination register, write data
//   B_GNT               port B grant (combinational)
//   CLR_REQ             request to zero all registers
//   CLR_BUSY            clear sweep in progress
//   CLR_DONE            one-cycle pulse alongside the last zero write
//   WRITE/INADDRESS/IN  registered write port into the register file
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_GNT,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_GNT,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic              prio_q,  prio_d;    // 0: A preferred on a tie
  logic [ADDR_W-1:0] cnt_q,   cnt_d;     // next address of the clear sweep
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic arb_open;

  // The cycle carrying the last zero write is already in ARB, but it still
  // belongs to the sweep on the bus, so grants stay closed until the next one.
  assign arb_open = (state_q == ST_ARB) && RESET && !CLR_REQ && !done_q;

  always_comb begin
    A_GNT = arb_open && A_REQ && (!B_REQ || !prio_q);
    B_GNT = arb_open && B_REQ && (!A_REQ ||  prio_q);
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_ARB: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          write_d = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = {{(ADDR_W-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
        end else if (A_GNT) begin
          write_d = 1'b1;
          addr_d  = A_ADDR;
          data_d  = A_DATA;
          prio_d  = 1'b1;
        end else if (B_GNT) begin
          write_d = 1'b1;
          addr_d  = B_ADDR;
          data_d  = B_DATA;
          prio_d  = 1'b0;
        end
      end

      ST_CLEAR: begin
        write_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_ARB;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_ARB;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign WRITE     = write_q;
  assign INADDRESS = addr_q;
  assign IN        = data_q;
  assign CLR_BUSY  = busy_q;
  assign CLR_DONE  = done_q;

endmodule
